dmac_chan_arbiter: RTL and testbench

Parametrised channel-request arbiter and bus-handshake controller for the DMA controller. Generalises the fixed two-channel request handling to `NUM_CH` channels. Supports selectable fixed-priority or round-robin arbitration, per-channel enable masking, and sticky per-channel completion and error status. Sits between the peripheral request lines and the channel transfer engine inside `Dmac_Top`, and owns `Bus_Req`/`Bus_Grant` towards the system arbiter.

---
 rtl/dmac_chan_arbiter_pkg.sv | 35 +++
 rtl/dmac_chan_arbiter_if.sv | 32 +++
 rtl/dmac_chan_arbiter_rr_picker.sv | 41 ++++
 rtl/dmac_chan_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmac_chan_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmac_chan_arbiter_pkg.sv
// Shared state encoding, arbitration-mode constants and priority-encode helpers
// for the DMA channel arbiter.
package dmac_chan_arbiter_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;
    localparam int MAX_CH     = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_BUS = 3'd1,
        ST_ACK     = 3'd2,
        ST_BUSY    = 3'd3,
        ST_DONE    = 3'd4
    } dmac_arb_state_e;

    function automatic int lowest_set(input logic [MAX_CH-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic int highest_set(input logic [MAX_CH-1:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/dmac_chan_arbiter_if.sv
// Request/handshake/status bundle between the arbiter (master side) and the
// peripherals, transfer engine and system bus arbiter (slave side).
interface dmac_chan_arbiter_if #(
    parameter int NUM_CH = 4
) ();
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] DmacReq;
    logic [NUM_CH-1:0] Ch_Enable;
    logic              Bus_Grant;
    logic              Xfer_Done;
    logic              Xfer_Err;
    logic [NUM_CH-1:0] Irq_Clr;
    logic              Bus_Req;
    logic [NUM_CH-1:0] ReqAck;
    logic              Ch_Start;
    logic [CH_W-1:0]   Ch_Sel;
    logic              Ch_Pause;
    logic [NUM_CH-1:0] Done_Status;
    logic [NUM_CH-1:0] Err_Status;
    logic              Interrupt;

    modport master (
        input  DmacReq, Ch_Enable, Bus_Grant, Xfer_Done, Xfer_Err, Irq_Clr,
        output Bus_Req, ReqAck, Ch_Start, Ch_Sel, Ch_Pause, Done_Status, Err_Status, Interrupt
    );

    modport slave (
        output DmacReq, Ch_Enable, Bus_Grant, Xfer_Done, Xfer_Err, Irq_Clr,
        input  Bus_Req, ReqAck, Ch_Start, Ch_Sel, Ch_Pause, Done_Status, Err_Status, Interrupt
    );
endinterface

// File: rtl/dmac_chan_arbiter_rr_picker.sv
// Combinational winner selection: highest index in fixed mode, or the first
// pending channel at or above base (with wrap) in round-robin mode.
module dmac_chan_arbiter_rr_picker
    import dmac_chan_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pend,
    input  logic [CH_W-1:0]   base,
    input  logic              mode,
    output logic [CH_W-1:0]   winner,
    output logic              valid
);

    logic [NUM_CH-1:0] rot_s;
    int                rr_idx_s;
    int                fix_idx_s;

    // Rotate the pending vector so that the search base lands on bit 0.
    always_comb begin
        rot_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rot_s[i] = pend[CH_W'((i + int'(base)) % NUM_CH)];
        end
    end

    assign rr_idx_s  = (lowest_set(MAX_CH'(rot_s)) + int'(base)) % NUM_CH;
    assign fix_idx_s = highest_set(MAX_CH'(pend));
    assign valid     = |pend;

    // Select the winner for the configured arbitration mode.
    always_comb begin
        if (mode) begin
            winner = CH_W'(rr_idx_s);
        end else begin
            winner = CH_W'(fix_idx_s);
        end
    end

endmodule

// File: rtl/dmac_chan_arbiter.sv
// DMA channel arbiter: picks a requesting channel, negotiates the system bus,
// hands the channel to the transfer engine and keeps sticky done/error status.
module dmac_chan_arbiter
    import dmac_chan_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int PRIO_MODE = 0
) (
    input logic                 clk,
    input logic                 rst,
    dmac_chan_arbiter_if.master bus
);

    localparam int                CH_W     = $clog2(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    dmac_arb_state_e   state_r;
    dmac_arb_state_e   state_nxt_s;
    logic [CH_W-1:0]   ch_sel_r, ch_sel_nxt_s;
    logic [CH_W-1:0]   last_r, last_nxt_s;
    logic [CH_W-1:0]   base_s, winner_s;
    logic [NUM_CH-1:0] pend_s, sel_hot_s;
    logic [NUM_CH-1:0] req_ack_r, req_ack_nxt_s;
    logic [NUM_CH-1:0] done_r, done_nxt_s, err_r, err_nxt_s;
    logic              bus_req_r, bus_req_nxt_s;
    logic              ch_start_r, ch_start_nxt_s;
    logic              valid_s, finish_s;

    assign pend_s    = bus.DmacReq & bus.Ch_Enable;
    assign base_s    = (last_r == CH_W'(NUM_CH - 1)) ? '0 : last_r + CH_W'(1'b1);
    assign sel_hot_s = ONE_HOT0 << ch_sel_r;
    assign finish_s  = (state_r == ST_BUSY) && bus.Xfer_Done;

    dmac_chan_arbiter_rr_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .pend   (pend_s),
        .base   (base_s),
        .mode   (PRIO_MODE == PRIO_RR),
        .winner (winner_s),
        .valid  (valid_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode; a grant beats a simultaneous request drop.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (valid_s) state_nxt_s = ST_REQ_BUS;
                else         state_nxt_s = ST_IDLE;
            end
            ST_REQ_BUS: begin
                if (bus.Bus_Grant)                state_nxt_s = ST_ACK;
                else if (!bus.DmacReq[ch_sel_r]) state_nxt_s = ST_IDLE;
                else                              state_nxt_s = ST_REQ_BUS;
            end
            ST_ACK: begin
                state_nxt_s = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.Xfer_Done) state_nxt_s = ST_DONE;
                else               state_nxt_s = ST_BUSY;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode, computed from the upcoming state so outputs can be registered.
    always_comb begin
        bus_req_nxt_s  = 1'b0;
        req_ack_nxt_s  = '0;
        ch_start_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_REQ_BUS: begin
                bus_req_nxt_s = 1'b1;
            end
            ST_ACK: begin
                bus_req_nxt_s  = 1'b1;
                req_ack_nxt_s  = sel_hot_s;
                ch_start_nxt_s = 1'b1;
            end
            ST_BUSY: begin
                bus_req_nxt_s = 1'b1;
            end
            default: begin
                bus_req_nxt_s = 1'b0;
            end
        endcase
    end

    // Channel latch, RR pointer and sticky status next values; a set beats a clear.
    always_comb begin
        if ((state_r == ST_IDLE) && valid_s) ch_sel_nxt_s = winner_s;
        else                                 ch_sel_nxt_s = ch_sel_r;

        if (state_r == ST_DONE) last_nxt_s = ch_sel_r;
        else                    last_nxt_s = last_r;

        done_nxt_s = (done_r & ~bus.Irq_Clr) | (finish_s ? sel_hot_s : '0);
        err_nxt_s  = (err_r & ~bus.Irq_Clr) | ((finish_s && bus.Xfer_Err) ? sel_hot_s : '0);
    end

    // Registered handshake outputs, selection, pointer and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_r  <= 1'b0;
            req_ack_r  <= '0;
            ch_start_r <= 1'b0;
            ch_sel_r   <= '0;
            last_r     <= CH_W'(NUM_CH - 1);
            done_r     <= '0;
            err_r      <= '0;
        end else begin
            bus_req_r  <= bus_req_nxt_s;
            req_ack_r  <= req_ack_nxt_s;
            ch_start_r <= ch_start_nxt_s;
            ch_sel_r   <= ch_sel_nxt_s;
            last_r     <= last_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    assign bus.Bus_Req     = bus_req_r;
    assign bus.ReqAck      = req_ack_r;
    assign bus.Ch_Start    = ch_start_r;
    assign bus.Ch_Sel      = ch_sel_r;
    assign bus.Ch_Pause    = (state_r == ST_BUSY) && !bus.Bus_Grant;
    assign bus.Done_Status = done_r;
    assign bus.Err_Status  = err_r;
    assign bus.Interrupt   = |(done_r | err_r);

endmodule

// File: tb/tb_dmac_chan_arbiter.sv
// Self-checking bench: a fixed-priority and a round-robin arbiter share one stimulus
// stream; a transfer-level reference model predicts every output each cycle.
module tb_dmac_chan_arbiter;

    localparam int NUM_CH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] en  = 4'b1111;
    logic [3:0] clr = 4'b0000;
    logic       grant = 1'b0;
    logic       xdone = 1'b0;
    logic       xerr  = 1'b0;
    int         checks = 0;
    int         errors = 0;

    dmac_chan_arbiter_if #(.NUM_CH(NUM_CH)) bus_f ();
    dmac_chan_arbiter_if #(.NUM_CH(NUM_CH)) bus_r ();

    dmac_chan_arbiter #(.NUM_CH(NUM_CH), .PRIO_MODE(0)) u_fix (.clk(clk), .rst(rst), .bus(bus_f));
    dmac_chan_arbiter #(.NUM_CH(NUM_CH), .PRIO_MODE(1)) u_rr  (.clk(clk), .rst(rst), .bus(bus_r));

    always #5 clk = ~clk;

    assign bus_f.DmacReq = req;   assign bus_r.DmacReq = req;
    assign bus_f.Ch_Enable = en;  assign bus_r.Ch_Enable = en;
    assign bus_f.Bus_Grant = grant; assign bus_r.Bus_Grant = grant;
    assign bus_f.Xfer_Done = xdone; assign bus_r.Xfer_Done = xdone;
    assign bus_f.Xfer_Err = xerr;   assign bus_r.Xfer_Err = xerr;
    assign bus_f.Irq_Clr = clr;     assign bus_r.Irq_Clr = clr;

    logic [17:0] obs [2];
    assign obs[0] = {bus_f.Bus_Req, bus_f.ReqAck, bus_f.Ch_Start, bus_f.Ch_Sel, bus_f.Ch_Pause,
                     bus_f.Done_Status, bus_f.Err_Status, bus_f.Interrupt};
    assign obs[1] = {bus_r.Bus_Req, bus_r.ReqAck, bus_r.Ch_Start, bus_r.Ch_Sel, bus_r.Ch_Pause,
                     bus_r.Done_Status, bus_r.Err_Status, bus_r.Interrupt};

    // Reference model, index 0 = fixed priority, 1 = round robin.
    int         m_sel [2];
    int         m_last[2];
    bit         m_ask [2];
    bit         m_ack [2];
    bit         m_busy[2];
    bit         m_rel [2];
    logic [3:0] m_done[2];
    logic [3:0] m_err [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = 0;  m_last[k] = NUM_CH - 1;
            m_ask[k] = 1'b0; m_ack[k] = 1'b0; m_busy[k] = 1'b0; m_rel[k] = 1'b0;
            m_done[k] = 4'b0000; m_err[k] = 4'b0000;
        end
    endfunction

    function automatic int ref_pick(input int k, input logic [3:0] pend);
        int w;
        w = -1;
        if (k == 0) begin
            for (int c = 0; c < NUM_CH; c++) if (pend[c]) w = c;
        end else begin
            for (int off = NUM_CH; off >= 1; off--) begin
                int c;
                c = (m_last[k] + off) % NUM_CH;
                if (pend[c]) w = c;
            end
        end
        return w;
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] hot;
            int         w;
            hot = 4'b0001 << m_sel[k];
            m_done[k] = m_done[k] & ~clr;
            m_err[k]  = m_err[k] & ~clr;
            if (m_busy[k] && xdone) begin
                m_done[k] = m_done[k] | hot;
                if (xerr) m_err[k] = m_err[k] | hot;
            end
            if (m_rel[k]) begin
                m_last[k] = m_sel[k];
                m_rel[k]  = 1'b0;
            end else if (m_busy[k]) begin
                if (xdone) begin m_busy[k] = 1'b0; m_rel[k] = 1'b1; end
            end else if (m_ack[k]) begin
                m_ack[k] = 1'b0; m_busy[k] = 1'b1;
            end else if (m_ask[k]) begin
                if (grant) begin m_ask[k] = 1'b0; m_ack[k] = 1'b1; end
                else if (!req[2'(m_sel[k])]) m_ask[k] = 1'b0;
            end else begin
                w = ref_pick(k, req & en);
                if (w >= 0) begin m_sel[k] = w; m_ask[k] = 1'b1; end
            end
        end
    endfunction

    function automatic logic [17:0] expect_vec(input int k);
        logic [3:0] hot;
        hot = 4'b0001 << m_sel[k];
        return {m_ask[k] | m_ack[k] | m_busy[k], m_ack[k] ? hot : 4'b0000, m_ack[k], 2'(m_sel[k]),
                m_busy[k] & ~grant, m_done[k], m_err[k], |(m_done[k] | m_err[k])};
    endfunction

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            checks++;
            assert (obs[k] === expect_vec(k)) else begin
                errors++;
                $error("FAIL model inst=%0d t=%0t observed=%h expected=%h", k, $time, obs[k], expect_vec(k));
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0; req = 4'b0000; en = 4'b1111; clr = 4'b0000;
        grant = 1'b0; xdone = 1'b0; xerr = 1'b0;
        model_reset();
        repeat (2) cycle();
        rst = 1'b1;
    endtask

    task automatic wait_ack(input int k, output int n);
        logic [3:0] a;
        n = 0;
        a = (k == 0) ? bus_f.ReqAck : bus_r.ReqAck;
        while (n < 12 && a === 4'b0000) begin
            cycle();
            n++;
            a = (k == 0) ? bus_f.ReqAck : bus_r.ReqAck;
        end
        checks++;
        assert (a !== 4'b0000) else begin
            errors++;
            $error("FAIL wait_ack inst=%0d observed=timeout expected=ack", k);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();
        chk("reset_bus_req", 32'(bus_r.Bus_Req), 32'd0);
        chk("reset_last_rr_base", 32'(bus_r.Ch_Sel), 32'd0);

        // Fixed priority: channel 2 wins over 1, then channel 1 follows.
        req = 4'b0110; grant = 1'b1;
        repeat (2) cycle();
        chk("fix_sel", 32'(bus_f.Ch_Sel), 32'd2);
        chk("fix_ack", 32'(bus_f.ReqAck), 32'b0100);
        cycle();
        xdone = 1'b1; req = 4'b0010;
        cycle();
        xdone = 1'b0;
        chk("fix_done", 32'(bus_f.Done_Status), 32'b0100);
        chk("fix_irq", 32'(bus_f.Interrupt), 32'd1);
        repeat (3) cycle();
        chk("fix_next_ack", 32'(bus_f.ReqAck), 32'b0010);

        // Round robin with all channels requesting.
        do_reset();
        req = 4'b1111; grant = 1'b1;
        for (int t = 0; t < 5; t++) begin
            wait_ack(1, n);
            chk("rr_order", 32'(bus_r.ReqAck), 32'b0001 << (t % 4));
            chk("rr_gap", 32'(n), (t == 0) ? 32'd2 : 32'd3);
            cycle();
            xdone = 1'b1;
            cycle();
            xdone = 1'b0;
            chk("rr_release", 32'(bus_r.Bus_Req), 32'd0);
        end

        // Enable masking.
        do_reset();
        req = 4'b0100; en = 4'b1011;
        repeat (3) cycle();
        chk("mask_f", 32'(bus_f.Bus_Req), 32'd0);
        chk("mask_r", 32'(bus_r.Bus_Req), 32'd0);
        en = 4'b1111;
        cycle();
        chk("unmask_f", 32'(bus_f.Bus_Req), 32'd1);
        chk("unmask_r", 32'(bus_r.Bus_Req), 32'd1);

        // Request dropped before grant: abandon without touching the RR pointer.
        do_reset();
        req = 4'b0010;
        repeat (2) cycle();
        chk("drop_sel", 32'(bus_r.Ch_Sel), 32'd1);
        req = 4'b0000;
        cycle();
        chk("drop_bus_req", 32'(bus_r.Bus_Req), 32'd0);
        chk("drop_no_ack", 32'(bus_r.ReqAck), 32'd0);
        req = 4'b1111; grant = 1'b1;
        wait_ack(1, n);
        chk("rr_ptr_kept", 32'(bus_r.ReqAck), 32'b0001);

        // Grant lost mid-transfer, error completion, clear racing a set.
        cycle();
        grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("pause", 32'(bus_r.Ch_Pause), 32'd1);
            chk("pause_bus_req", 32'(bus_r.Bus_Req), 32'd1);
        end
        grant = 1'b1; xdone = 1'b1; xerr = 1'b1;
        cycle();
        xdone = 1'b0; xerr = 1'b0;
        chk("err_set", 32'(bus_r.Err_Status), 32'b0001);
        wait_ack(1, n);
        cycle();
        clr = 4'b1111; xdone = 1'b1;
        cycle();
        clr = 4'b0000; xdone = 1'b0;
        chk("set_beats_clr", 32'(bus_r.Done_Status), 32'b0010);
        chk("clr_err", 32'(bus_r.Err_Status), 32'b0000);

        // Asynchronous reset in BUSY.
        wait_ack(1, n);
        cycle();
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("arst_bus_req_r", 32'(bus_r.Bus_Req), 32'd0);
        chk("arst_bus_req_f", 32'(bus_f.Bus_Req), 32'd0);
        chk("arst_ack", 32'(bus_r.ReqAck), 32'd0);
        chk("arst_start", 32'(bus_r.Ch_Start), 32'd0);
        chk("arst_done", 32'(bus_r.Done_Status), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_ack(1, n);
        chk("arst_rr_first", 32'(bus_r.ReqAck), 32'b0001);

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            req   = 4'($urandom);
            en    = 4'($urandom) | 4'($urandom);
            grant = ($urandom_range(0, 3) != 0);
            xdone = ($urandom_range(0, 4) == 0);
            xerr  = 1'($urandom);
            clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
